// File: rtl/ff_array_pkg.sv
// Shared constants and types for the two-port flip-flop register array.
// Error flag bit positions, error flag vector type and error counter width.
package ff_array_pkg;

  localparam int unsigned ERR_WR_RANGE  = 0;
  localparam int unsigned ERR_RD_RANGE  = 1;
  localparam int unsigned ERR_RD_UNINIT = 2;
  localparam int unsigned ERR_W         = 3;

  localparam int unsigned ERR_CNT_W = 8;

  typedef logic [ERR_W-1:0] err_flags_t;

endpackage

// File: rtl/ff_array_err_cnt.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones,
// and is cleared only by reset.
module ff_array_err_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold once saturated.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ff_array_2p.sv
// Two-port flip-flop register array: one write port and one registered read
// port, per-entry valid tracking, address range checking for any DEPTH and a
// saturating error counter.
// Build option: define FF_ARRAY_BYPASS_EN to forward write data to a
// same-address read in the same cycle; otherwise reads see the old contents.
module ff_array_2p
  import ff_array_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 rd,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 clr,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 error,
  output err_flags_t           err_flags,
  output logic [ERR_CNT_W-1:0] err_count
);

  // One bit per encodable address, set where the address maps to an entry.
  // A lookup avoids constant-range compares when DEPTH is a power of two.
  localparam int unsigned NSLOT = 1 << AW;
  localparam logic [NSLOT-1:0] ADDR_OK = {NSLOT{1'b1}} >> (NSLOT - DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] dout_d;
  logic             dout_valid_d;
  err_flags_t       flags_d;

  assign wr_ok = ADDR_OK[wr_addr];
  assign rd_ok = ADDR_OK[rd_addr];

  // Storage update: clear beats write, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (wr && wr_ok) begin
      mem[wr_addr]   <= din;
      valid[wr_addr] <= 1'b1;
    end
  end

  // Read result and fault decode for the current request.
  always_comb begin
    dout_d       = '0;
    dout_valid_d = 1'b0;
    flags_d      = '0;
    flags_d[ERR_WR_RANGE] = wr && !wr_ok;
    if (rd) begin
      if (!rd_ok) begin
        flags_d[ERR_RD_RANGE] = 1'b1;
`ifdef FF_ARRAY_BYPASS_EN
      end else if (wr && wr_ok && !clr && (wr_addr == rd_addr)) begin
        dout_d       = din;
        dout_valid_d = 1'b1;
`endif
      end else if (!valid[rd_addr]) begin
        flags_d[ERR_RD_UNINIT] = 1'b1;
      end else begin
        dout_d       = mem[rd_addr];
        dout_valid_d = 1'b1;
      end
    end
  end

  // Register read data and flags so they share the one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err_flags  <= '0;
      error      <= 1'b0;
    end else begin
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      err_flags  <= flags_d;
      error      <= |flags_d;
    end
  end

  // Counts registered error pulses, so it trails error by one cycle.
  ff_array_err_cnt #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (error),
    .count  (err_count)
  );

endmodule

// File: tb/tb_ff_array_2p.sv
// Directed self-checking bench for ff_array_2p: an 8-entry and a 6-entry
// instance share the same stimulus.
module tb_ff_array_2p;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr;
  logic [2:0] wr_addr;
  logic [7:0] din;
  logic       rd;
  logic [2:0] rd_addr;
  logic       clr;

  logic [7:0] dout8, dout6;
  logic       dv8, dv6;
  logic       err8, err6;
  logic [2:0] flg8, flg6;
  logic [7:0] cnt8, cnt6;

  int checks = 0;
  int errors = 0;

  logic [7:0] byp_exp;

  always #5 clk = ~clk;

  ff_array_2p #(
    .WIDTH (8),
    .DEPTH (8)
  ) u8 (
    .clk        (clk),
    .resetn     (resetn),
    .wr         (wr),
    .wr_addr    (wr_addr),
    .din        (din),
    .rd         (rd),
    .rd_addr    (rd_addr),
    .clr        (clr),
    .dout       (dout8),
    .dout_valid (dv8),
    .error      (err8),
    .err_flags  (flg8),
    .err_count  (cnt8)
  );

  ff_array_2p #(
    .WIDTH (8),
    .DEPTH (6)
  ) u6 (
    .clk        (clk),
    .resetn     (resetn),
    .wr         (wr),
    .wr_addr    (wr_addr),
    .din        (din),
    .rd         (rd),
    .rd_addr    (rd_addr),
    .clr        (clr),
    .dout       (dout6),
    .dout_valid (dv6),
    .error      (err6),
    .err_flags  (flg6),
    .err_count  (cnt6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; wr_addr = '0; din = '0; rd = 1'b0; rd_addr = '0; clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    cyc();
    cyc();
    chk("rst_dout", dout8, 8'h00);
    chk("rst_dv", dv8, 1'b0);
    chk("rst_err", err8, 1'b0);
    chk("rst_flags", flg8, 3'b000);
    chk("rst_cnt", cnt8, 8'd0);
    resetn = 1'b1;

    // Uninitialised read after reset.
    rd = 1'b1; rd_addr = 3'd3;
    cyc();
    chk("uninit_dout", dout8, 8'h00);
    chk("uninit_dv", dv8, 1'b0);
    chk("uninit_flags", flg8, 3'b100);
    chk("uninit_err", err8, 1'b1);
    idle();
    cyc();
    chk("uninit_cnt", cnt8, 8'd1);
    chk("uninit_flags_clear", flg8, 3'b000);
    chk("uninit_cnt6", cnt6, 8'd1);

    // Write then read back.
    wr = 1'b1; wr_addr = 3'd5; din = 8'hA5;
    cyc();
    idle();
    rd = 1'b1; rd_addr = 3'd5;
    cyc();
    chk("rw_dout", dout8, 8'hA5);
    chk("rw_dv", dv8, 1'b1);
    chk("rw_err", err8, 1'b0);
    chk("rw_dout6", dout6, 8'hA5);

    // DEPTH=6: out-of-range write and read together.
    idle();
    wr = 1'b1; wr_addr = 3'd7; din = 8'h11; rd = 1'b1; rd_addr = 3'd6;
    cyc();
    chk("range_flags6", flg6, 3'b011);
    chk("range_err6", err6, 1'b1);
    chk("range_dv6", dv6, 1'b0);
    idle();
    cyc();
    chk("range_cnt6", cnt6, 8'd2);
    for (int i = 0; i < 6; i++) begin
      rd = 1'b1; rd_addr = 3'(i);
      cyc();
      chk($sformatf("scan6_dout_%0d", i), dout6, (i == 5) ? 8'hA5 : 8'h00);
      chk($sformatf("scan6_dv_%0d", i), dv6, (i == 5) ? 1'b1 : 1'b0);
    end

    // Same-address read/write collision.
    do_reset();
    wr = 1'b1; wr_addr = 3'd2; din = 8'h3C;
    cyc();
    wr = 1'b1; wr_addr = 3'd2; din = 8'h77; rd = 1'b1; rd_addr = 3'd2;
    cyc();
`ifdef FF_ARRAY_BYPASS_EN
    byp_exp = 8'h77;
`else
    byp_exp = 8'h3C;
`endif
    chk("coll_dout", dout8, byp_exp);
    chk("coll_dv", dv8, 1'b1);
    chk("coll_err", err8, 1'b0);
    idle();
    rd = 1'b1; rd_addr = 3'd2;
    cyc();
    chk("coll_next_dout", dout8, 8'h77);

    // Clear with concurrent write and read.
    idle();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wr_addr = 3'(i); din = 8'h10 + 8'(i);
      cyc();
    end
    wr = 1'b1; wr_addr = 3'd1; din = 8'hFF; rd = 1'b1; rd_addr = 3'd4; clr = 1'b1;
    cyc();
    chk("clr_dout", dout8, 8'h14);
    chk("clr_dv", dv8, 1'b1);
    chk("clr_flags", flg8, 3'b000);
    idle();
    rd = 1'b1; rd_addr = 3'd1;
    cyc();
    chk("clr_after_dout", dout8, 8'h00);
    chk("clr_after_dv", dv8, 1'b0);
    chk("clr_after_flags", flg8, 3'b100);

    // Saturating error counter, then reset mid-stream.
    do_reset();
    rd = 1'b1; rd_addr = 3'd3;
    for (int i = 0; i < 10; i++) cyc();
    chk("sat_cnt_10", cnt8, 8'd9);
    for (int i = 10; i < 300; i++) cyc();
    chk("sat_cnt_300", cnt8, 8'd255);
    chk("sat_err", err8, 1'b1);
    resetn = 1'b0;
    cyc();
    chk("midrst_dout", dout8, 8'h00);
    chk("midrst_dv", dv8, 1'b0);
    chk("midrst_err", err8, 1'b0);
    chk("midrst_flags", flg8, 3'b000);
    chk("midrst_cnt", cnt8, 8'd0);
    resetn = 1'b1;
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_array_2p.md
# ff_array_2p

Parametrised two-port flip-flop register array with one write port and one registered read port, both usable in the same cycle. Per-entry valid tracking detects reads of unwritten entries. Range checking covers non-power-of-two depths. Saturating error accounting is included. This is the general-purpose successor of the 8x8 single-port FF array, intended for small config/lookup tables inside datapath blocks.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of two)
- AW, $clog2(DEPTH), address width; derived, not overridden
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- wr  in  1  write request
- wr_addr  in  AW  write address
- din  in  WIDTH  write data
- rd  in  1  read request
- rd_addr  in  AW  read address
- clr  in  1  invalidate all entries
- dout  out  WIDTH  read data, registered
- dout_valid  out  1  dout holds a legal read result
- error  out  1  one-cycle pulse, OR of err_flags
- err_flags  out  3  {rd_uninit, rd_range, wr_range}, registered
- err_count  out  8  cycles with error=1, saturating at 255

## Operation
- Reset (resetn=0 at edge): mem all 0, valid all 0, dout=0, dout_valid=0, error=0, err_flags=0, err_count=0. Reset overrides all requests.
- Write, wr=1, wr_addr<DEPTH: mem[wr_addr]<=din, valid[wr_addr]<=1.
- Write, wr_addr>=DEPTH: write dropped, wr_range flag set.
- Read, rd=1, rd_addr<DEPTH, valid: dout<=mem[rd_addr], dout_valid<=1.
- Read, out of range: dout<=0, dout_valid<=0, rd_range set; rd_uninit not evaluated.
- Read, in range but valid=0: dout<=0, dout_valid<=0, rd_uninit set.
- rd=0: dout<=0, dout_valid<=0.
- rd and wr in the same cycle are legal; this is not an error, unlike the predecessor. Different addresses are fully independent.
- Same-address rd/wr collision: see Configuration.
- clr=1: all valid bits cleared and all mem cleared to 0 at the edge. clr beats wr in the same cycle; the write is dropped without error. wr_range is still flagged if wr_addr>=DEPTH.
- A read in a clr cycle returns pre-clear contents. No bypass applies in a clr cycle.
- err_flags are rewritten every cycle: multiple flags may be set together, and all are 0 when there is no fault.
- err_count increments by 1 per cycle in which any flag is set, not per flag. It holds at 255 and is cleared only by reset.

## Timing
- Read latency 1 cycle: request at edge N, dout/dout_valid/err_flags valid after edge N+1 and held for exactly 1 cycle.
- Write is visible to a read issued in the following cycle.
- error and err_flags are aligned with dout. err_count reflects a fault one cycle after error pulses.
- No backpressure; a request is accepted every cycle.

## Configuration
- FF_ARRAY_BYPASS_EN defined: on a same-address rd/wr collision (in range, clr=0), dout<=din and dout_valid<=1, even if the entry was previously invalid. No rd_uninit is raised.
- FF_ARRAY_BYPASS_EN undefined: read-before-write. dout returns the old contents, and rd_uninit is raised if the entry was invalid. The new data is visible from the next cycle.

## Structure
- Package ff_array_pkg holds:
  - localparams ERR_WR_RANGE=0, ERR_RD_RANGE=1, ERR_RD_UNINIT=2, ERR_W=3
  - ERR_CNT_W=8
  - typedef err_flags_t (logic [ERR_W-1:0])
- Sub-module ff_array_err_cnt: saturating counter with parameter W, inputs clk, resetn, inc; output count.
- Storage is an unpacked FF array plus a DEPTH-bit valid vector. No SRAM macro is used.

## Test plan
- Reset, then rd addr 3 -> dout=0x00, dout_valid=0, err_flags=3'b100, err_count=1 one cycle later.
- wr addr 5 din 0xA5; next cycle rd addr 5 -> dout=0xA5, dout_valid=1, error=0.
- DEPTH=6: wr addr 7 din 0x11 and rd addr 6 in the same cycle -> err_flags=3'b011, error=1, err_count +1 (not +2); a later rd of every address shows 0x11 stored nowhere.
- Write addr 2 = 0x3C, then rd addr 2 with wr addr 2 din 0x77 in the same cycle:
  - bypass on -> dout=0x77
  - bypass off -> dout=0x3C, and next rd -> 0x77
- Write addrs 0..7, then clr with wr addr 1 din 0xFF and rd addr 4 in the same cycle -> read returns the pre-clear value; next rd addr 1 -> rd_uninit, dout=0.
- Force 300 faulting cycles -> err_count stops at 255; resetn mid-stream -> all outputs 0 at the next edge.
